dog_scheduler: RTL and testbench

- Per-octave sequencer for the DoG subtraction engine.
- When a Gaussian octave's BRAMs are complete, it runs NUM_SCALES-1 DoG passes (scale k minus scale k+1) back to back on a single shared engine.
- For each pass it steers the sharper/fuzzier read mux and the destination DoG bank, and launches the engine.
- Downstream, it gates each launch on the keypoint stage having released the destination bank, and it watchdogs the engine.

---
 rtl/sift_pkg.sv | 29 ++
 rtl/dog_scheduler_if.sv | 43 ++++
 rtl/dog_watchdog.sv | 46 ++++
 rtl/dog_scheduler.sv | 178 +++++++++++++++++
 tb/tb_dog_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sift_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | sift_pkg : shared types/constants for the SIFT DoG scheduling slice   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package sift_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHECK     = 3'd1,
    ST_LAUNCH    = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_RUN       = 3'd4,
    ST_NEXT      = 3'd5,
    ST_FINISH    = 3'd6,
    ST_ERR       = 3'd7
  } sched_state_t;

  localparam int NUM_SCALES_DEFAULT = 4;
  localparam int ENGINE_ACK_CYCLES  = 4;

  // A select for n choices; a single choice still gets one wire.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dog_scheduler_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | dog_scheduler_if : octave/engine/consumer handshake bundle           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface dog_scheduler_if
  import sift_pkg::*;
#(
  parameter int NUM_SCALES = NUM_SCALES_DEFAULT
);
  localparam int SEL_W  = sel_width(NUM_SCALES);
  localparam int BANK_W = sel_width(NUM_SCALES - 1);
  localparam int NB     = NUM_SCALES - 1;

  logic              octave_ready;
  logic              dog_busy;
  logic              dog_done;
  logic [NB-1:0]     bank_free;
  logic              dog_go;
  logic [SEL_W-1:0]  sharp_sel;
  logic [SEL_W-1:0]  fuzz_sel;
  logic [BANK_W-1:0] bank_sel;
  logic [NB-1:0]     bank_claim;
  logic              busy;
  logic              octave_done;
  logic              error;
  logic [2:0]        state_num;

  modport master (
    input  octave_ready, dog_busy, dog_done, bank_free,
    output dog_go, sharp_sel, fuzz_sel, bank_sel, bank_claim,
           busy, octave_done, error, state_num
  );

  modport slave (
    output octave_ready, dog_busy, dog_done, bank_free,
    input  dog_go, sharp_sel, fuzz_sel, bank_sel, bank_claim,
           busy, octave_done, error, state_num
  );

endinterface
`default_nettype wire

// File: rtl/dog_watchdog.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | dog_watchdog : per-pass cycle counter with ack and timeout flags      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dog_watchdog
  import sift_pkg::*;
#(
  parameter int TIMEOUT = 32768,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_in,
  input  logic clear,
  input  logic enable,
  output logic expired,
  output logic ack_expired
);

  logic [CNT_W-1:0] count_q, count_d;

  // Count holds k-1 in the k-th cycle after launch, so the flags fire in the
  // cycle where the running total reaches the limit.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired     = (count_q == CNT_W'(TIMEOUT - 1));
  assign ack_expired = (count_q == CNT_W'(ENGINE_ACK_CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/dog_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | dog_scheduler : sequences NUM_SCALES-1 DoG passes per Gaussian octave |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dog_scheduler
  import sift_pkg::*;
#(
  parameter int DIMENSION  = 64,
  parameter int NUM_SCALES = NUM_SCALES_DEFAULT,
  parameter int TIMEOUT    = 8 * DIMENSION * DIMENSION
) (
  input logic             clk,
  input logic             rst_in,
  dog_scheduler_if.master bus
);

  localparam int SEL_W  = sel_width(NUM_SCALES);
  localparam int BANK_W = sel_width(NUM_SCALES - 1);
  localparam int NB     = NUM_SCALES - 1;

  localparam logic [SEL_W-1:0] LAST_PASS = SEL_W'(NUM_SCALES - 2);
  localparam logic [NB-1:0]    CLAIM_ONE = NB'(1);

  sched_state_t      state_q, state_d;
  logic [SEL_W-1:0]  pass_q, pass_d;
  logic              hist_q, hist_d;
  logic [SEL_W-1:0]  sharp_q, sharp_d;
  logic [SEL_W-1:0]  fuzz_q, fuzz_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic              go_q, go_d;
  logic [NB-1:0]     claim_q, claim_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic wd_clear;
  logic wd_enable;
  logic wd_expired;
  logic wd_ack_expired;

  dog_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk         (clk),
    .rst_in      (rst_in),
    .clear       (wd_clear),
    .enable      (wd_enable),
    .expired     (wd_expired),
    .ack_expired (wd_ack_expired)
  );

  // Pulse outputs are set on the transition into the state that owns them,
  // so dog_go is high exactly while in LAUNCH and octave_done while in FINISH.
  always_comb begin
    state_d   = state_q;
    pass_d    = pass_q;
    hist_d    = bus.octave_ready;
    sharp_d   = sharp_q;
    fuzz_d    = fuzz_q;
    bank_d    = bank_q;
    go_d      = 1'b0;
    claim_d   = '0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    wd_clear  = 1'b0;
    wd_enable = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.octave_ready && !hist_q) begin
          state_d = ST_CHECK;
          pass_d  = '0;
          busy_d  = 1'b1;
          sharp_d = '0;
          fuzz_d  = SEL_W'(1);
          bank_d  = '0;
        end
      end
      ST_CHECK: begin
        if (bus.bank_free[pass_q]) begin
          state_d = ST_LAUNCH;
          go_d    = 1'b1;
        end
      end
      ST_LAUNCH: begin
        wd_clear = 1'b1;
        state_d  = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        wd_enable = 1'b1;
        if (bus.dog_busy) begin
          state_d = ST_RUN;
        end else if (wd_ack_expired) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end
      end
      ST_RUN: begin
        wd_enable = 1'b1;
        // Done is checked first so a completion on the last allowed cycle wins.
        if (bus.dog_done) begin
          state_d = ST_NEXT;
          claim_d = CLAIM_ONE << pass_q;
        end else if (wd_expired) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end
      end
      ST_NEXT: begin
        if (pass_q == LAST_PASS) begin
          state_d = ST_FINISH;
          done_d  = 1'b1;
        end else begin
          state_d = ST_CHECK;
          pass_d  = pass_q + 1'b1;
          sharp_d = pass_q + 1'b1;
          fuzz_d  = pass_q + SEL_W'(2);
          bank_d  = BANK_W'(pass_q + 1'b1);
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
      pass_q  <= '0;
      hist_q  <= 1'b0;
      sharp_q <= '0;
      fuzz_q  <= '0;
      bank_q  <= '0;
      go_q    <= 1'b0;
      claim_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      hist_q  <= hist_d;
      sharp_q <= sharp_d;
      fuzz_q  <= fuzz_d;
      bank_q  <= bank_d;
      go_q    <= go_d;
      claim_q <= claim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.dog_go      = go_q;
  assign bus.sharp_sel   = sharp_q;
  assign bus.fuzz_sel    = fuzz_q;
  assign bus.bank_sel    = bank_q;
  assign bus.bank_claim  = claim_q;
  assign bus.busy        = busy_q;
  assign bus.octave_done = done_q;
  assign bus.error       = err_q;
  assign bus.state_num   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_dog_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dog_scheduler : scoreboard bench with a behavioural DoG engine     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_dog_scheduler;

  logic clk = 1'b0;
  logic rst_in;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dog_scheduler_if #(.NUM_SCALES(4)) bus_if ();

  dog_scheduler #(
    .DIMENSION  (64),
    .NUM_SCALES (4),
    .TIMEOUT    (200)
  ) dut (
    .clk    (clk),
    .rst_in (rst_in),
    .bus    (bus_if)
  );

  typedef struct {
    int sharp;
    int fuzz;
    int bank;
    int at;
  } go_exp_t;

  typedef struct {
    int val;
    int at;
  } claim_exp_t;

  go_exp_t    exp_go[$];
  claim_exp_t exp_claim[$];
  int         exp_done[$];
  int         exp_err[$];

  int checks = 0;
  int errors = 0;

  // Engine model knobs: busy two cycles after go, done eng_done_at cycles after go.
  bit eng_mute    = 1'b0;
  int eng_done_at = 100;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic push_pass(input int k, input int g, input int d, input bit last);
    go_exp_t    ge;
    claim_exp_t ce;
    ge.sharp = k; ge.fuzz = k + 1; ge.bank = k; ge.at = g;
    exp_go.push_back(ge);
    ce.val = 1 << k; ce.at = g + d + 1;
    exp_claim.push_back(ce);
    if (last) exp_done.push_back(g + d + 2);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_go"},    int'(bus_if.dog_go), 0);
    chk({tag, "_sharp"}, int'(bus_if.sharp_sel), 0);
    chk({tag, "_fuzz"},  int'(bus_if.fuzz_sel), 0);
    chk({tag, "_bank"},  int'(bus_if.bank_sel), 0);
    chk({tag, "_claim"}, int'(bus_if.bank_claim), 0);
    chk({tag, "_busy"},  int'(bus_if.busy), 0);
    chk({tag, "_odone"}, int'(bus_if.octave_done), 0);
    chk({tag, "_error"}, int'(bus_if.error), 0);
    chk({tag, "_state"}, int'(bus_if.state_num), 0);
  endtask

  // Full octave from a rising octave_ready driven now; passes spaced by d+3.
  task automatic run_full(input int d, input string tag);
    int c;
    c = cyc;
    bus_if.octave_ready = 1'b1;
    for (int k = 0; k < 3; k++) push_pass(k, c + 2 + k * (d + 3), d, k == 2);
    wait_until(c + 2 + 2 * (d + 3) + d + 2 + 5);
    chk({tag, "_busy_end"},  int'(bus_if.busy), 0);
    chk({tag, "_error_end"}, int'(bus_if.error), 0);
    chk({tag, "_state_end"}, int'(bus_if.state_num), 0);
  endtask

  task automatic drop_ready;
    bus_if.octave_ready = 1'b0;
    @(negedge clk);
  endtask

  // Engine model
  initial begin : engine
    bit eng_active;
    int eng_cnt;
    eng_active = 1'b0;
    eng_cnt    = 0;
    bus_if.dog_busy = 1'b0;
    bus_if.dog_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus_if.dog_done = 1'b0;
      if (rst_in !== 1'b1) begin
        eng_active = 1'b0;
        bus_if.dog_busy = 1'b0;
      end else if (bus_if.dog_go) begin
        eng_active = 1'b1;
        eng_cnt    = 0;
      end else if (eng_active) begin
        eng_cnt++;
        if (eng_cnt == 2 && !eng_mute) bus_if.dog_busy = 1'b1;
        if (eng_done_at != 0 && eng_cnt == eng_done_at) bus_if.dog_done = 1'b1;
        if (eng_done_at != 0 && eng_cnt == eng_done_at + 1) begin
          bus_if.dog_busy = 1'b0;
          eng_active = 1'b0;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an event
  initial begin : monitor
    go_exp_t    ge;
    claim_exp_t ce;
    int         t;
    logic       err_prev;
    err_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_if.dog_go === 1'b1) begin
        if (exp_go.size() == 0) chk("unexpected_go", 1, 0);
        else begin
          ge = exp_go.pop_front();
          chk("go_sharp_sel", int'(bus_if.sharp_sel), ge.sharp);
          chk("go_fuzz_sel",  int'(bus_if.fuzz_sel),  ge.fuzz);
          chk("go_bank_sel",  int'(bus_if.bank_sel),  ge.bank);
          chk("go_cycle",     cyc, ge.at);
        end
      end
      if (bus_if.bank_claim !== 3'b000) begin
        if (exp_claim.size() == 0) chk("unexpected_claim", int'(bus_if.bank_claim), 0);
        else begin
          ce = exp_claim.pop_front();
          chk("claim_value", int'(bus_if.bank_claim), ce.val);
          chk("claim_cycle", cyc, ce.at);
        end
      end
      if (bus_if.octave_done === 1'b1) begin
        if (exp_done.size() == 0) chk("unexpected_octave_done", 1, 0);
        else begin
          t = exp_done.pop_front();
          chk("octave_done_cycle", cyc, t);
        end
      end
      if (bus_if.error === 1'b1 && err_prev !== 1'b1) begin
        if (exp_err.size() == 0) chk("unexpected_error", 1, 0);
        else begin
          t = exp_err.pop_front();
          chk("error_cycle", cyc, t);
        end
      end
      err_prev = bus_if.error;
    end
  end

  initial begin : guard
    #1000000;
    $display("FAIL global_time_limit actual=%0d cycles expected=finish", cyc);
    $fatal(1, "time limit");
  end

  initial begin : stimulus
    int c;
    int r;
    rst_in = 1'b0;
    bus_if.octave_ready = 1'b0;
    bus_if.bank_free    = 3'b000;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_in = 1'b1;
    bus_if.bank_free = 3'b111;
    @(negedge clk);

    // Normal octave, then octave_ready held high must not retrigger
    c = cyc;
    fork
      run_full(100, "normal");
      begin
        @(negedge clk);
        chk("busy_after_edge", int'(bus_if.busy), 1);
        chk("state_check", int'(bus_if.state_num), 1);
      end
    join
    wait_until(cyc + 20);
    chk("held_high_state", int'(bus_if.state_num), 0);
    chk("held_high_busy", int'(bus_if.busy), 0);

    // Bank 1 not released: hold in CHECK for 50 cycles
    bus_if.bank_free = 3'b101;
    drop_ready();
    c = cyc;
    bus_if.octave_ready = 1'b1;
    push_pass(0, c + 2, 100, 1'b0);
    wait_until(c + 104);
    chk("hold_state_start", int'(bus_if.state_num), 1);
    wait_until(c + 153);
    chk("hold_state_end", int'(bus_if.state_num), 1);
    chk("hold_go_low", int'(bus_if.dog_go), 0);
    chk("hold_bank_sel", int'(bus_if.bank_sel), 1);
    @(negedge clk);
    r = cyc;
    // bank_free is sampled at the next edge, which enters LAUNCH with dog_go
    bus_if.bank_free = 3'b111;
    push_pass(1, r + 1, 100, 1'b0);
    push_pass(2, r + 104, 100, 1'b1);
    wait_until(r + 215);
    chk("hold_error_end", int'(bus_if.error), 0);

    // Reset during pass 1, then a clean restart from pass 0
    drop_ready();
    c = cyc;
    bus_if.octave_ready = 1'b1;
    push_pass(0, c + 2, 100, 1'b0);
    begin
      go_exp_t ge;
      ge.sharp = 1; ge.fuzz = 2; ge.bank = 1; ge.at = c + 105;
      exp_go.push_back(ge);
    end
    wait_until(c + 150);
    chk("midpass_state", int'(bus_if.state_num), 4);
    rst_in = 1'b0;
    bus_if.octave_ready = 1'b0;
    @(negedge clk);
    check_idle_outputs("midreset");
    rst_in = 1'b1;
    @(negedge clk);
    run_full(100, "restart");

    // Engine never acknowledges: error on 5th cycle after dog_go
    eng_mute = 1'b1;
    eng_done_at = 0;
    drop_ready();
    c = cyc;
    bus_if.octave_ready = 1'b1;
    begin
      go_exp_t ge;
      ge.sharp = 0; ge.fuzz = 1; ge.bank = 0; ge.at = c + 2;
      exp_go.push_back(ge);
    end
    exp_err.push_back(c + 7);
    wait_until(c + 12);
    chk("noack_error", int'(bus_if.error), 1);
    chk("noack_busy", int'(bus_if.busy), 0);
    chk("noack_state", int'(bus_if.state_num), 7);
    drop_ready();
    bus_if.octave_ready = 1'b1;
    wait_until(cyc + 10);
    chk("err_ignores_ready", int'(bus_if.state_num), 7);
    chk("err_sticky", int'(bus_if.error), 1);
    rst_in = 1'b0;
    bus_if.octave_ready = 1'b0;
    @(negedge clk);
    rst_in = 1'b1;
    chk("err_cleared", int'(bus_if.error), 0);
    eng_mute = 1'b0;
    @(negedge clk);

    // Done withheld: watchdog reaches TIMEOUT=200
    c = cyc;
    bus_if.octave_ready = 1'b1;
    begin
      go_exp_t ge;
      ge.sharp = 0; ge.fuzz = 1; ge.bank = 0; ge.at = c + 2;
      exp_go.push_back(ge);
    end
    exp_err.push_back(c + 203);
    wait_until(c + 201);
    chk("timeout_not_yet", int'(bus_if.error), 0);
    wait_until(c + 210);
    chk("timeout_state", int'(bus_if.state_num), 7);
    rst_in = 1'b0;
    bus_if.octave_ready = 1'b0;
    @(negedge clk);
    rst_in = 1'b1;
    @(negedge clk);

    // Done on exactly cycle 200 of each pass: done wins over timeout
    eng_done_at = 200;
    run_full(200, "edge_done");

    chk("left_go",    exp_go.size(), 0);
    chk("left_claim", exp_claim.size(), 0);
    chk("left_done",  exp_done.size(), 0);
    chk("left_err",   exp_err.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
